// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous-read data memory between the core (default priority) and a DMA port with a starvation bound
module data_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CORE_REQ,
  input  logic                  CORE_WR_EN,
  input  logic [ADDR_WIDTH-1:0] CORE_ADDR,
  input  logic [DATA_WIDTH-1:0] CORE_WDATA,
  output logic [DATA_WIDTH-1:0] CORE_RDATA,
  output logic                  CORE_STALL,
  input  logic                  DMA_REQ,
  input  logic                  DMA_WR_EN,
  input  logic [ADDR_WIDTH-1:0] DMA_ADDR,
  input  logic [DATA_WIDTH-1:0] DMA_WDATA,
  output logic                  DMA_GNT,
  output logic [DATA_WIDTH-1:0] DMA_RDATA,
  output logic                  DMA_RVALID,
  output logic                  MEM_EN,
  output logic                  MEM_WR_EN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);
  typedef enum logic [1:0] {IDLE, CORE_RD, DMA_RD} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dma_wins, core_wins, act;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    dma_wins  = state_q == IDLE && DMA_REQ && (!CORE_REQ || cnt_q == LIMIT);
    core_wins = state_q == IDLE && CORE_REQ && !dma_wins;
    state_d   = core_wins && !CORE_WR_EN ? CORE_RD :
                dma_wins && !DMA_WR_EN   ? DMA_RD  : IDLE;
    // a waiting DMA request ages in every ungranted cycle, including return cycles
    cnt_d     = dma_wins                   ? 4'd0         :
                DMA_REQ && cnt_q != LIMIT  ? cnt_q + 4'd1 : cnt_q;
  end
  always_comb begin
    act        = !RST;
    MEM_EN     = act && (core_wins || dma_wins);
    MEM_WR_EN  = act && (core_wins ? CORE_WR_EN : dma_wins && DMA_WR_EN);
    MEM_ADDR   = !act ? '0 : core_wins ? CORE_ADDR  : dma_wins ? DMA_ADDR  : '0;
    MEM_WDATA  = !act ? '0 : core_wins ? CORE_WDATA : dma_wins ? DMA_WDATA : '0;
    CORE_STALL = act && ((core_wins && !CORE_WR_EN) || ((dma_wins || state_q == DMA_RD) && CORE_REQ));
    CORE_RDATA = act && state_q == CORE_RD ? MEM_RDATA : '0;
    DMA_GNT    = act && dma_wins;
    DMA_RVALID = act && state_q == DMA_RD;
    DMA_RDATA  = act && state_q == DMA_RD ? MEM_RDATA : '0;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port external data memory between the single-cycle MIPS core and a DMA/debug loader port.
- Core has default priority. The DMA port is protected from starvation by a bounded wait counter.
- Core writes complete in one cycle with no stall.
- Core loads stall the core for exactly one cycle to absorb the memory's 1-cycle synchronous read latency.
- Sits between the core's data-memory interface (ALU result as address, RD2 as write data, mem-write enable) and the data memory.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- STARVE_LIMIT, 4, consecutive DMA wait cycles before DMA wins over core; legal range 1..15

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- CORE_REQ  input  1  core data access this cycle (load or store)
- CORE_WR_EN  input  1  1 = store, 0 = load; qualified by CORE_REQ
- CORE_ADDR  input  ADDR_WIDTH  core byte address
- CORE_WDATA  input  DATA_WIDTH  core store data
- CORE_RDATA  output  DATA_WIDTH  load data; valid only in CORE_RD state, 0 otherwise
- CORE_STALL  output  1  core must hold PC and all inputs this cycle
- DMA_REQ  input  1  DMA access request; held with stable ADDR/WR_EN/WDATA until DMA_GNT
- DMA_WR_EN  input  1  1 = write, 0 = read
- DMA_ADDR  input  ADDR_WIDTH  DMA address
- DMA_WDATA  input  DATA_WIDTH  DMA write data
- DMA_GNT  output  1  request accepted this cycle (combinational)
- DMA_RDATA  output  DATA_WIDTH  read data; valid when DMA_RVALID=1, 0 otherwise
- DMA_RVALID  output  1  one-cycle pulse, the cycle after a granted DMA read
- MEM_EN  output  1  memory access enable
- MEM_WR_EN  output  1  memory write enable
- MEM_ADDR  output  ADDR_WIDTH  memory address
- MEM_WDATA  output  DATA_WIDTH  memory write data
- MEM_RDATA  input  DATA_WIDTH  memory read data, valid 1 cycle after a read issue

Behaviour:
- Reset
  - RST=1 at a rising edge: state := IDLE, starve counter := 0.
  - While RST=1, all outputs are forced to 0.
  - Reset mid-read: pending read is discarded; no RVALID and no CORE_RDATA is produced.
- FSM states: IDLE (issue slot), CORE_RD (core data return), DMA_RD (DMA data return).
- IDLE winner selection
  - dma_wins = DMA_REQ & (!CORE_REQ | cnt == STARVE_LIMIT).
  - core_wins = CORE_REQ & !dma_wins.
- IDLE, core wins
  - MEM_EN=1, MEM_WR_EN=CORE_WR_EN, MEM_ADDR=CORE_ADDR, MEM_WDATA=CORE_WDATA.
  - Store: CORE_STALL=0, stay in IDLE.
  - Load: CORE_STALL=1, next state CORE_RD.
- IDLE, DMA wins
  - DMA_GNT=1; memory driven from the DMA inputs; cnt := 0.
  - Read: next state DMA_RD. Write: stay in IDLE.
  - If CORE_REQ=1, CORE_STALL=1.
- IDLE, no request: MEM_EN=0; all memory outputs 0.
- CORE_RD
  - CORE_RDATA=MEM_RDATA, CORE_STALL=0, MEM_EN=0. Next state IDLE.
  - The still-asserted CORE_REQ is the same load and is not reissued.
  - DMA is not granted this cycle.
- DMA_RD
  - DMA_RVALID=1, DMA_RDATA=MEM_RDATA, MEM_EN=0, no grants. Next state IDLE.
  - If CORE_REQ=1, CORE_STALL=1.
- Starve counter
  - Increments in any cycle where DMA_REQ=1 and DMA_GNT=0, including CORE_RD and DMA_RD cycles.
  - Saturates at STARVE_LIMIT.
  - Cleared on grant or reset.
- Latency
  - Core store: 0 extra cycles.
  - Core load: 1 stall cycle.
  - DMA read: data 1 cycle after grant.
  - Worst-case DMA wait under continuous core traffic: STARVE_LIMIT cycles plus at most one CORE_RD cycle.
- Simultaneous core store and DMA request with cnt < STARVE_LIMIT: core wins, DMA waits, cnt increments.
- Back-to-back DMA: a write may be granted every IDLE cycle. A read occupies 2 cycles.

Test Plan:
- Core store, DMA idle: CORE_REQ=1, WR_EN=1, ADDR=84, WDATA=7 → same cycle MEM_EN=1, MEM_WR_EN=1, MEM_ADDR=84, MEM_WDATA=7, CORE_STALL=0; state stays IDLE.
- Core load from 84 holding 7: issue cycle CORE_STALL=1 and MEM_EN=1; next cycle CORE_RDATA=7, CORE_STALL=0, MEM_EN=0; following cycle back in IDLE.
- Starvation: CORE_REQ store held high every cycle, DMA write to 80 with data 0x55 asserted, STARVE_LIMIT=4 → DMA_GNT on the 5th cycle; CORE_STALL=1 that cycle only; memory sees write 80/0x55; cnt=0 afterwards.
- DMA read of 80 (holding 0x55), core idle → DMA_GNT same cycle; DMA_RVALID=1 and DMA_RDATA=0x55 next cycle; a core load arriving in that cycle sees CORE_STALL=1 and is issued the cycle after.
- Reset mid-read: RST=1 during the CORE_RD cycle → next cycle all outputs 0; after release a new load to 84 behaves as a normal 1-stall load; no spurious RVALID.
- Idle with no requests for 10 cycles → MEM_EN=0, DMA_GNT=0, CORE_STALL=0 every cycle; counter stays 0.
